pipe_addsub: RTL

//   Parametrised, pipelined two's-complement adder/subtractor for the ALU datapath.
//   - Carry chain is split into STAGES equal chunks, one register stage per chunk.
//   - A valid/ready handshake carries operands in and results out, with full backpressure.
//   - Produces carry, signed-overflow and zero flags with each result.
//   - Sits between the operand mux and the ALU result mux; one issue per cycle when unstalled.

---
 rtl/pipe_addsub.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pipe_addsub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_addsub
// Description : Pipelined two's-complement adder/subtractor with a
//               valid/ready handshake and full backpressure. The carry chain
//               is cut into STAGES equal chunks; stage k adds chunk k and
//               registers the carry for stage k+1. The last stage also forms
//               the carry, signed-overflow and zero flags.
//
// Parameters  : WIDTH  - operand/result width (WIDTH % STAGES must be 0)
//               STAGES - pipeline depth, 1..4
//
// Ports       : CLK        rising-edge clock
//               RST_N      asynchronous active-low reset
//               in_valid   operands A, B, op_sub are valid
//               in_ready   block accepts operands this cycle
//               A, B       operands
//               op_sub     0: A+B, 1: A-B
//               out_valid  r and flags are valid
//               out_ready  consumer takes the result this cycle
//               r          result
//               cout       carry out of MSB (subtract: 1 = no borrow)
//               ovf        signed overflow of the true result
//               zero       r == 0 (after any saturation)
//
// Build option: ADDSUB_SAT_EN - when defined, an overflowing result is
//               clamped to the signed limit selected by the sign of A.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = WIDTH / STAGES;

    // The whole pipeline moves as one shift register; it only stalls when
    // the output holds a result nobody has taken yet.
    logic w_advance;

    // Inputs seen by each stage: index 0 comes from the ports, index k from
    // the registers of stage k-1.
    logic             w_v   [STAGES];
    logic [WIDTH-1:0] w_a   [STAGES];
    logic [WIDTH-1:0] w_bx  [STAGES];
    logic [WIDTH-1:0] w_sum [STAGES];
    logic             w_c   [STAGES];

    // Output registers
    logic             r_out_valid;
    logic [WIDTH-1:0] r_res;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    // Subtraction is A + ~B + 1: invert B up front and inject the +1 as the
    // carry into chunk 0.
    assign w_v[0]   = in_valid;
    assign w_a[0]   = A;
    assign w_bx[0]  = op_sub ? ~B : B;
    assign w_sum[0] = '0;
    assign w_c[0]   = op_sub;

    assign out_valid = r_out_valid;
    assign r         = r_res;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW:0]      w_chunk;
        logic [WIDTH-1:0] w_next_sum;

        assign w_chunk = {1'b0, w_a[k][k*CW +: CW]}
                       + {1'b0, w_bx[k][k*CW +: CW]}
                       + {{CW{1'b0}}, w_c[k]};

        // Lower chunks were filled in by earlier stages; drop this stage's
        // chunk into place.
        always_comb begin
            w_next_sum                = w_sum[k];
            w_next_sum[k*CW +: CW]    = w_chunk[CW-1:0];
        end

        if (k < STAGES - 1) begin : g_mid
            logic             r_v;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_bx;
            logic [WIDTH-1:0] r_sum;
            logic             r_c;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_v   <= 1'b0;
                    r_a   <= '0;
                    r_bx  <= '0;
                    r_sum <= '0;
                    r_c   <= 1'b0;
                end else if (w_advance) begin
                    r_v   <= w_v[k];
                    r_a   <= w_a[k];
                    r_bx  <= w_bx[k];
                    r_sum <= w_next_sum;
                    r_c   <= w_chunk[CW];
                end
            end

            assign w_v[k+1]   = r_v;
            assign w_a[k+1]   = r_a;
            assign w_bx[k+1]  = r_bx;
            assign w_sum[k+1] = r_sum;
            assign w_c[k+1]   = r_c;
        end else begin : g_last
            logic             w_ovf;
            logic [WIDTH-1:0] w_res;

            // Same-sign operands whose sum flips sign overflowed.
            assign w_ovf = (w_a[k][WIDTH-1] == w_bx[k][WIDTH-1])
                        && (w_next_sum[WIDTH-1] != w_a[k][WIDTH-1]);

`ifdef ADDSUB_SAT_EN
            localparam logic [WIDTH-1:0] c_pos_max = {1'b0, {(WIDTH-1){1'b1}}};
            localparam logic [WIDTH-1:0] c_neg_min = {1'b1, {(WIDTH-1){1'b0}}};

            // On overflow the true result has the sign of A, so A's sign
            // picks the limit.
            assign w_res = w_ovf ? (w_a[k][WIDTH-1] ? c_neg_min : c_pos_max)
                                 : w_next_sum;
`else
            assign w_res = w_next_sum;
`endif

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_out_valid <= 1'b0;
                    r_res       <= '0;
                    r_cout      <= 1'b0;
                    r_ovf       <= 1'b0;
                    r_zero      <= 1'b0;
                end else if (w_advance) begin
                    r_out_valid <= w_v[k];
                    r_res       <= w_res;
                    r_cout      <= w_chunk[CW];
                    r_ovf       <= w_ovf;
                    r_zero      <= (w_res == '0);
                end
            end
        end
    end

endmodule
`default_nettype wire
